// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: fetch-stage bus bundle (imem req/ack, redirect, decode valid/ready)
// Ports (master = fetch unit, slave = imem/decode/branch side):
//   imem_req, imem_addr[31:0]  fetch request and word-aligned address
//   imem_ack, imem_rdata[31:0] imem accept and returned word, same cycle
//   redirect, redirect_pc[31:0] flush and restart fetch
//   inst_valid, inst[31:0], inst_pc[31:0], inst_ready  queue head to decode
interface ifetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner, imem req/ack master and {pc,inst} FIFO feeding decode
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ifetch_queue_if.master (imem handshake, redirect, decode handshake)
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
    state_t        state, state_next;
    logic [31:0]   fpc, fpc_next, drop_addr, target;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc [DEPTH];
    logic          push, pop;
    assign target = bus.redirect_pc & ~32'h3;
    assign push = (state == WAIT) & bus.imem_ack & ~bus.redirect;
    assign pop = bus.inst_valid & bus.inst_ready;
    // redirect flushes and wins over any same-cycle push/pop
    assign count_next = bus.redirect ? '0 : count + CW'(push) - CW'(pop);
    assign bus.imem_req = (state != IDLE);
    // DROP keeps presenting the abandoned address until imem acks it
    assign bus.imem_addr = (state == DROP) ? drop_addr : fpc;
    assign bus.inst_valid = (count != '0);
    assign bus.inst = mem_inst[rd_ptr];
    assign bus.inst_pc = mem_pc[rd_ptr];
    always_comb begin
        state_next = state;
        fpc_next = fpc;
        case (state)
            IDLE: begin
                if (bus.redirect) fpc_next = target;
                else if (count != FULL) state_next = WAIT;
            end
            WAIT: begin
                if (bus.redirect) begin
                    fpc_next = target;
                    state_next = bus.imem_ack ? IDLE : DROP;
                end else if (bus.imem_ack) begin
                    fpc_next = fpc + 32'd4;
                    // slot for the next word is reserved only while space remains
                    state_next = (count_next == FULL) ? IDLE : WAIT;
                end
            end
            DROP: begin
                if (bus.redirect) fpc_next = target;
                if (bus.imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fpc <= RESET_PC;
            drop_addr <= RESET_PC;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i] <= '0;
            end
        end else begin
            state <= state_next;
            fpc <= fpc_next;
            count <= count_next;
            if (state == WAIT && bus.redirect && !bus.imem_ack) drop_addr <= fpc;
            if (push) begin
                mem_inst[wr_ptr] <= bus.imem_rdata;
                mem_pc[wr_ptr] <= fpc;
            end
            rd_ptr <= bus.redirect ? '0 : rd_ptr + AW'(pop);
            wr_ptr <= bus.redirect ? '0 : wr_ptr + AW'(push);
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue
module tb_ifetch_queue;
    localparam logic [31:0] K = 32'hC0DE_0000;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_bad = 0;
    ifetch_queue_if bus ();
    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // imem returns a word derived from the address so every PC has a unique word
    assign bus.imem_rdata = bus.imem_addr ^ K;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask
    task automatic do_reset;
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        cyc(1);
        rst = 1'b0;
    endtask
    task automatic wait_req(input string tag);
        for (int i = 0; i < 8 && !bus.imem_req; i++) @(negedge clk);
        check(tag, {31'b0, bus.imem_req}, 32'd1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        cyc(2);
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_pc", bus.inst_pc, 32'h0);
        // 1: streaming, one instruction per cycle
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        bus.inst_ready = 1'b1;
        cyc(1);
        check("t1_req", {31'b0, bus.imem_req}, 32'd1);
        check("t1_addr0", bus.imem_addr, 32'h0);
        check("t1_valid0", {31'b0, bus.inst_valid}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            check("t1_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("t1_pc", bus.inst_pc, 32'(4 * k));
            check("t1_inst", bus.inst, 32'(4 * k) ^ K);
            check("t1_addr", bus.imem_addr, 32'(4 * k + 4));
        end
        // 2: decode stalled, queue fills to DEPTH and fetch stops
        do_reset();
        bus.imem_ack = 1'b1;
        cyc(5);
        check("t2_req_full", {31'b0, bus.imem_req}, 32'd0);
        check("t2_head", bus.inst_pc, 32'h0);
        cyc(1);
        check("t2_req_hold", {31'b0, bus.imem_req}, 32'd0);
        check("t2_head_hold", bus.inst_pc, 32'h0);
        check("t2_inst_hold", bus.inst, K);
        bus.imem_ack = 1'b0;
        bus.inst_ready = 1'b1;
        wait_req("t2_req_resume");
        check("t2_addr_resume", bus.imem_addr, 32'h10);
        // 3: redirect while waiting on a slow imem
        do_reset();
        cyc(1);
        check("t3_req", {31'b0, bus.imem_req}, 32'd1);
        check("t3_addr", bus.imem_addr, 32'h0);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        cyc(1);
        bus.redirect = 1'b0;
        check("t3_drop_req", {31'b0, bus.imem_req}, 32'd1);
        check("t3_drop_addr", bus.imem_addr, 32'h0);
        cyc(1);
        check("t3_drop_addr2", bus.imem_addr, 32'h0);
        bus.imem_ack = 1'b1;
        cyc(1);
        check("t3_no_enq", {31'b0, bus.inst_valid}, 32'd0);
        wait_req("t3_req_new");
        check("t3_addr_new", bus.imem_addr, 32'h100);
        cyc(1);
        check("t3_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("t3_pc", bus.inst_pc, 32'h100);
        check("t3_inst", bus.inst, 32'h100 ^ K);
        // 4: redirect coinciding with ack and pop, two entries queued
        do_reset();
        bus.imem_ack = 1'b1;
        cyc(3);
        check("t4_head", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        cyc(1);
        bus.redirect = 1'b0;
        check("t4_flush", {31'b0, bus.inst_valid}, 32'd0);
        wait_req("t4_req");
        check("t4_addr", bus.imem_addr, 32'h200);
        cyc(1);
        check("t4_pc", bus.inst_pc, 32'h200);
        check("t4_valid", {31'b0, bus.inst_valid}, 32'd1);
        // 5: redirect target alignment and PC wrap
        do_reset();
        bus.inst_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h103;
        cyc(1);
        bus.redirect = 1'b0;
        wait_req("t5_req");
        check("t5_addr_align", bus.imem_addr, 32'h100);
        bus.imem_ack = 1'b1;
        cyc(1);
        check("t5_pc", bus.inst_pc, 32'h100);
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        cyc(1);
        bus.redirect = 1'b0;
        check("t5_flush", {31'b0, bus.inst_valid}, 32'd0);
        check("t5_drop_addr", bus.imem_addr, 32'h104);
        bus.imem_ack = 1'b1;
        cyc(1);
        wait_req("t5_req_top");
        check("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        check("t5_pc_top", bus.inst_pc, 32'hFFFF_FFFC);
        check("t5_wrap", bus.imem_addr, 32'h0);
        // 6: reset with entries queued and a request outstanding
        do_reset();
        bus.imem_ack = 1'b1;
        cyc(4);
        check("t6_head", bus.inst_pc, 32'h0);
        bus.imem_ack = 1'b0;
        cyc(1);
        check("t6_out_req", {31'b0, bus.imem_req}, 32'd1);
        check("t6_out_addr", bus.imem_addr, 32'hC);
        rst = 1'b1;
        cyc(1);
        check("t6_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("t6_req", {31'b0, bus.imem_req}, 32'd0);
        check("t6_addr", bus.imem_addr, 32'h0);
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 8 && !bus.inst_valid; i++) @(negedge clk);
        check("t6_refetch", {31'b0, bus.inst_valid}, 32'd1);
        check("t6_refetch_pc", bus.inst_pc, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
